// File: rtl/rx_frame_checker.sv
// Buffers one UART frame (ADDR, LEN, payload, XOR checksum), checks checksum and
// inter-byte timeout, and forwards good frames without the checksum byte.
module rx_frame_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [CNT_W-1:0] csum_err_cnt,
  output logic [CNT_W-1:0] tmo_err_cnt,
  output logic             busy
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_ADDR, S_LEN, S_PAY, S_CSUM, S_CHECK, S_SEND
  } state_t;

  state_t r_state, w_next;

  logic             r_in_ready;
  logic [TW-1:0]    r_tmo;
  logic [7:0]       r_addr, r_len, r_xor, r_csum;
  logic [8:0]       r_cnt;
  logic [8:0]       r_snd_idx;
  logic [7:0]       r_rd_data;
  logic             r_out_valid, r_out_last;
  logic [7:0]       r_out_data;
  logic [CNT_W-1:0] r_csum_cnt, r_tmo_cnt;
  logic [7:0]       r_mem [0:256];

  logic       w_acc, w_tmo_hit, w_tmo_evt, w_csum_bad, w_load, w_fin;
  logic [8:0] w_last_idx, w_rd_addr;

  assign w_acc      = in_valid & r_in_ready;
  assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_last_idx = {1'b0, r_len} + 9'd1;
  assign w_load     = (r_state == S_SEND) && (!r_out_valid || out_ready) &&
                      (r_snd_idx <= w_last_idx);
  assign w_fin      = (r_state == S_SEND) && r_out_valid && out_ready && r_out_last;
  // Read one entry ahead when the output register advances, else re-read the held one.
  assign w_rd_addr  = w_load ? r_snd_idx : (r_snd_idx - 9'd1);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_ADDR;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_tmo_evt  = 1'b0;
    w_csum_bad = 1'b0;
    case (r_state)
      S_ADDR: if (w_acc) w_next = S_LEN;
      S_LEN: begin
        if (w_acc)          w_next = (in_data == 8'd0) ? S_CSUM : S_PAY;
        else if (w_tmo_hit) begin w_tmo_evt = 1'b1; w_next = S_ADDR; end
      end
      S_PAY: begin
        if (w_acc) begin
          if (r_cnt == {1'b0, r_len}) w_next = S_CSUM;
        end else if (w_tmo_hit) begin
          w_tmo_evt = 1'b1;
          w_next    = S_ADDR;
        end
      end
      S_CSUM: begin
        if (w_acc)          w_next = S_CHECK;
        else if (w_tmo_hit) begin w_tmo_evt = 1'b1; w_next = S_ADDR; end
      end
      S_CHECK: begin
        if (r_csum != r_xor) begin
          w_csum_bad = 1'b1;
          w_next     = S_ADDR;
        end else begin
          w_next = S_SEND;
        end
      end
      S_SEND:  if (w_fin) w_next = S_ADDR;
      default: w_next = S_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_tmo       <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_xor       <= '0;
      r_csum      <= '0;
      r_cnt       <= 9'd1;
      r_snd_idx   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_csum_cnt  <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      r_in_ready <= (w_next inside {S_ADDR, S_LEN, S_PAY, S_CSUM});

      if (w_acc || (r_state inside {S_ADDR, S_CHECK, S_SEND}) || (w_next == S_ADDR))
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + TW'(1);

      case (r_state)
        S_ADDR: begin
          r_xor <= w_acc ? in_data : '0;
          if (w_acc) r_addr <= in_data;
        end
        S_LEN: if (w_acc) begin
          r_len <= in_data;
          r_xor <= r_xor ^ in_data;
          r_cnt <= 9'd1;
        end
        S_PAY: if (w_acc) begin
          r_xor <= r_xor ^ in_data;
          r_cnt <= r_cnt + 9'd1;
        end
        S_CSUM:  if (w_acc) r_csum <= in_data;
        S_CHECK: r_snd_idx <= '0;
        default: ;
      endcase

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= (r_snd_idx == 9'd0) ? r_addr : r_rd_data;
        r_out_last  <= (r_snd_idx == w_last_idx);
        r_snd_idx   <= r_snd_idx + 9'd1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_csum_bad && (r_csum_cnt != '1)) r_csum_cnt <= r_csum_cnt + CNT_W'(1);
      if (w_tmo_evt  && (r_tmo_cnt  != '1)) r_tmo_cnt  <= r_tmo_cnt  + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && (r_state == S_LEN))      r_mem[0]     <= in_data;
    else if (w_acc && (r_state == S_PAY)) r_mem[r_cnt] <= in_data;
    if ((r_state == S_SEND) && (w_rd_addr <= 9'd256)) r_rd_data <= r_mem[w_rd_addr];
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_last     = r_out_last;
  assign csum_err_cnt = r_csum_cnt;
  assign tmo_err_cnt  = r_tmo_cnt;
  assign busy         = (r_state != S_ADDR);

endmodule

// File: tb/tb_rx_frame_checker.sv
// Scoreboard bench for rx_frame_checker: expected forwarded bytes are queued as
// frames are driven and popped by a monitor on each output handshake.
module tb_rx_frame_checker;

  localparam int unsigned T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;
  logic [7:0] csum_err_cnt, tmo_err_cnt;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int rx_count = 0;
  logic [8:0] sb [$];
  logic [7:0] pay_buf [256];
  logic       bp_done;

  rx_frame_checker #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last),
    .csum_err_cnt(csum_err_cnt), .tmo_err_cnt(tmo_err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs change 1 ns after posedge, so negedge values are what the next edge samples.
  logic       prev_stall = 1'b0;
  logic [8:0] prev_out   = '0;
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || {out_last, out_data} !== prev_out) begin
          errors++;
          $display("FAIL stall_stable: got v=%b %h/%b need v=1 %h/%b",
                   out_valid, out_data, out_last, prev_out[7:0], prev_out[8]);
        end
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_during_send: got %b need 0", in_ready);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        rx_count++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h last=%b need none", out_data, out_last);
        end else begin
          logic [8:0] exp;
          exp = sb.pop_front();
          if ({out_last, out_data} !== exp) begin
            errors++;
            $display("FAIL out_byte: got %h last=%b need %h last=%b",
                     out_data, out_last, exp[7:0], exp[8]);
          end
        end
      end
      prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
      prev_out   = {out_last, out_data};
    end
  end

  function automatic logic [7:0] csum_of(input logic [7:0] addr, input logic [7:0] len);
    logic [7:0] x;
    x = addr ^ len;
    for (int i = 0; i < int'(len); i++) x ^= pay_buf[i];
    return x;
  endfunction

  task automatic push_expected(input logic [7:0] addr, input logic [7:0] len);
    sb.push_back({1'b0, addr});
    sb.push_back({(len == 8'd0), len});
    for (int i = 0; i < int'(len); i++) sb.push_back({(i == int'(len) - 1), pay_buf[i]});
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic got;
    got = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL send_byte_wait: in_ready never 1 for byte %h", b);
    end
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [7:0] len,
                            input logic corrupt, input logic push);
    logic [7:0] c;
    c = csum_of(addr, len);
    if (corrupt) c ^= 8'h01;
    if (push) push_expected(addr, len);
    send_byte(addr);
    send_byte(len);
    for (int i = 0; i < int'(len); i++) send_byte(pay_buf[i]);
    send_byte(c);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy === 1'b0 && out_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: left=%0d busy=%b need 0/0", sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, out_last, out_data, csum_err_cnt, tmo_err_cnt, busy} !== '0) begin
      errors++;
      $display("FAIL reset_vals: got rdy=%b v=%b l=%b d=%h c=%0d t=%0d b=%b need all 0",
               in_ready, out_valid, out_last, out_data, csum_err_cnt, tmo_err_cnt, busy);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b need 1", in_ready);
    end
  endtask

  task automatic test_good_frame();
    pay_buf[0] = 8'h12; pay_buf[1] = 8'h34; pay_buf[2] = 8'h56;
    send_frame(8'h08, 8'd3, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_n0: got v=%b need 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_n1: got v=%b need 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h08) begin
      errors++;
      $display("FAIL latency_n2: got v=%b d=%h need v=1 d=08", out_valid, out_data);
    end
    wait_idle();
    checks++;
    if (csum_err_cnt !== 8'd0 || tmo_err_cnt !== 8'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL good_counters: got c=%0d t=%0d rdy=%b need 0 0 1",
               csum_err_cnt, tmo_err_cnt, in_ready);
    end
  endtask

  task automatic test_bad_csum();
    pay_buf[0] = 8'h12; pay_buf[1] = 8'h34; pay_buf[2] = 8'h56;
    send_frame(8'h08, 8'd3, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (csum_err_cnt !== 8'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum: got c=%0d rdy=%b v=%b need 1 1 0", csum_err_cnt, in_ready, out_valid);
    end
    wait_idle();
  endtask

  task automatic test_len0();
    send_frame(8'h16, 8'd0, 1'b0, 1'b1);
    wait_idle();
  endtask

  task automatic test_timeout();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (T - 1) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || tmo_err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL tmo_early: got busy=%b t=%0d need 1 0", busy, tmo_err_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || tmo_err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL tmo_fire: got busy=%b t=%0d need 0 1", busy, tmo_err_cnt);
    end
    pay_buf[0] = 8'hA5;
    send_frame(8'h09, 8'd1, 1'b0, 1'b1);
    wait_idle();
    // Byte lands on the same edge the limit is reached: accepted, no timeout.
    pay_buf[0] = 8'h3C;
    push_expected(8'h21, 8'd1);
    send_byte(8'h21);
    send_byte(8'h01);
    repeat (T - 1) @(posedge clk);
    #1;
    send_byte(8'h3C);
    send_byte(csum_of(8'h21, 8'd1));
    wait_idle();
    checks++;
    if (tmo_err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL tmo_byte_wins: got t=%0d need 1", tmo_err_cnt);
    end
  endtask

  task automatic test_backpressure();
    int start;
    for (int i = 0; i < 256; i++) pay_buf[i] = 8'($urandom_range(0, 255));
    start   = rx_count;
    bp_done = 1'b0;
    fork
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    send_frame(8'h5A, 8'd255, 1'b0, 1'b1);
    wait_idle();
    bp_done = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b1;
    checks++;
    if (rx_count - start != 257) begin
      errors++;
      $display("FAIL bp_count: got %0d need 257", rx_count - start);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'h44);
    send_byte(8'd5);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, out_last, out_data, csum_err_cnt, tmo_err_cnt, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_pay: got rdy=%b v=%b d=%h c=%0d t=%0d b=%b need all 0",
               in_ready, out_valid, out_data, csum_err_cnt, tmo_err_cnt, busy);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    pay_buf[0] = 8'h77; pay_buf[1] = 8'h88;
    send_frame(8'h33, 8'd2, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h33) begin
      errors++;
      $display("FAIL stall_hold: got v=%b d=%h need 1 33", out_valid, out_data);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, out_last, out_data, csum_err_cnt, tmo_err_cnt, busy} !== '0) begin
      errors++;
      $display("FAIL reset_mid_send: got rdy=%b v=%b d=%h c=%0d t=%0d b=%b need all 0",
               in_ready, out_valid, out_data, csum_err_cnt, tmo_err_cnt, busy);
    end
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    pay_buf[0] = 8'hC3; pay_buf[1] = 8'h01; pay_buf[2] = 8'hFE; pay_buf[3] = 8'h00;
    send_frame(8'h7E, 8'd4, 1'b0, 1'b1);
    wait_idle();
  endtask

  task automatic test_saturate();
    for (int f = 0; f < 300; f++) begin
      send_frame(8'(f), 8'd0, 1'b1, 1'b0);
      if (f == 253) begin
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (csum_err_cnt !== 8'd254) begin
          errors++;
          $display("FAIL csum_cnt_254: got %0d need 254", csum_err_cnt);
        end
      end
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (csum_err_cnt !== 8'd255 || tmo_err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL csum_saturate: got c=%0d t=%0d need 255 0", csum_err_cnt, tmo_err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len0();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left need 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
